gpu_memory_responder: RTL

// Multi-channel memory responder: the memory side of the valid/ready read/write channels the GPU top

---
 rtl/gpu_memory_responder_pkg.sv | 22 ++
 rtl/gpu_memory_responder_channel.sv | 127 ++++++++++++
 rtl/gpu_memory_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/gpu_memory_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpu_memory_responder_pkg : shared state encoding and sizing helper          |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package gpu_memory_responder_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_BUSY  = 3'd1,
    WRITE_BUSY = 3'd2,
    RESPOND    = 3'd3,
    RELEASE    = 3'd4
  } mem_resp_state_t;

  // Width of a counter/index able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_memory_responder_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder_channel : one channel FSM with latency counter and latches    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_responder_channel
  import gpu_memory_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     read_valid,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic                     write_valid,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  output logic                     read_ready,
  output logic                     write_ready,
  output logic                     accept,
  output logic [ADDRESS_WIDTH-1:0] accept_address,
  output logic                     rd_sample,
  output logic [ADDRESS_WIDTH-1:0] rd_address,
  output logic                     wr_commit,
  output logic [ADDRESS_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0]    wr_data
);

  localparam int c_MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int c_CNT_W   = clog2_min1(c_MAX_LAT);
  // BUSY lasts LATENCY-1 cycles, so the counter starts at LATENCY-2 and exits at zero.
  localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'((WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0);

  mem_resp_state_t          r_state;
  logic [c_CNT_W-1:0]       r_cnt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_is_read;
  logic                     r_read_ready;
  logic                     r_write_ready;
  logic                     w_take_read;
  logic                     w_take_write;

  assign w_take_read    = (r_state == IDLE) && read_valid;
  assign w_take_write   = (r_state == IDLE) && !read_valid && write_valid && (WRITE_ENABLE != 0);
  assign accept         = w_take_read || w_take_write;
  assign accept_address = w_take_read ? read_address : write_address;
  assign rd_sample      = (w_take_read && (READ_LATENCY == 1)) ||
                          ((r_state == READ_BUSY) && (r_cnt == '0));
  assign rd_address     = (r_state == IDLE) ? read_address : r_addr;
  assign wr_commit      = (r_state == RESPOND) && !r_is_read;
  assign wr_address     = r_addr;
  assign wr_data        = r_data;
  assign read_ready     = r_read_ready;
  assign write_ready    = r_write_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_is_read     <= 1'b0;
      r_read_ready  <= 1'b0;
      r_write_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take_read) begin
            r_addr    <= read_address;
            r_is_read <= 1'b1;
            r_cnt     <= c_RD_LOAD;
            if (READ_LATENCY == 1) begin
              r_state      <= RESPOND;
              r_read_ready <= 1'b1;
            end else begin
              r_state <= READ_BUSY;
            end
          end else if (w_take_write) begin
            r_addr    <= write_address;
            r_data    <= write_data;
            r_is_read <= 1'b0;
            r_cnt     <= c_WR_LOAD;
            if (WRITE_LATENCY == 1) begin
              r_state       <= RESPOND;
              r_write_ready <= 1'b1;
            end else begin
              r_state <= WRITE_BUSY;
            end
          end
        end
        READ_BUSY: begin
          if (r_cnt == '0) begin
            r_state      <= RESPOND;
            r_read_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WRITE_BUSY: begin
          if (r_cnt == '0) begin
            r_state       <= RESPOND;
            r_write_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESPOND: begin
          r_read_ready  <= 1'b0;
          r_write_ready <= 1'b0;
          r_state       <= RELEASE;
        end
        RELEASE: begin
          if (r_is_read ? !read_valid : !write_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpu_memory_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gpu_memory_responder : multi-channel fixed-latency memory with load port    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module gpu_memory_responder
  import gpu_memory_responder_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [NUM_CHANNELS-1:0]                     read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  read_address,
  output logic [NUM_CHANNELS-1:0]                     read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     read_data,
  input  logic [NUM_CHANNELS-1:0]                     write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     write_data,
  output logic [NUM_CHANNELS-1:0]                     write_ready,
  input  logic                                        load_valid,
  input  logic [ADDRESS_WIDTH-1:0]                    load_address,
  input  logic [DATA_WIDTH-1:0]                       load_data,
  output logic                                        oob_error
);

  localparam int c_IDX_W = clog2_min1(DEPTH);

  logic [DATA_WIDTH-1:0]                       r_mem [DEPTH];
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     r_read_data;
  logic                                        r_oob;
  logic [NUM_CHANNELS-1:0]                     w_write_ready;
  logic [NUM_CHANNELS-1:0]                     w_accept;
  logic [NUM_CHANNELS-1:0]                     w_rd_sample;
  logic [NUM_CHANNELS-1:0]                     w_wr_commit;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  w_accept_address;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  w_rd_address;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  w_wr_address;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     w_wr_data;
  logic                                        w_oob_hit;

  function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic [c_IDX_W-1:0] idx(input logic [ADDRESS_WIDTH-1:0] a);
    return a[c_IDX_W-1:0];
  endfunction

  generate
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
      mem_responder_channel #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .READ_LATENCY  (READ_LATENCY),
        .WRITE_LATENCY (WRITE_LATENCY),
        .WRITE_ENABLE  (WRITE_ENABLE)
      ) u_channel (
        .clk            (clk),
        .reset_n        (reset_n),
        .read_valid     (read_valid[i]),
        .read_address   (read_address[i]),
        .write_valid    (write_valid[i]),
        .write_address  (write_address[i]),
        .write_data     (write_data[i]),
        .read_ready     (read_ready[i]),
        .write_ready    (w_write_ready[i]),
        .accept         (w_accept[i]),
        .accept_address (w_accept_address[i]),
        .rd_sample      (w_rd_sample[i]),
        .rd_address     (w_rd_address[i]),
        .wr_commit      (w_wr_commit[i]),
        .wr_address     (w_wr_address[i]),
        .wr_data        (w_wr_data[i])
      );
    end
  endgenerate

  assign write_ready = (WRITE_ENABLE != 0) ? w_write_ready : '0;
  assign read_data   = r_read_data;
  assign oob_error   = r_oob;

  always_comb begin
    w_oob_hit = load_valid && !in_range(load_address);
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_accept[c] && !in_range(w_accept_address[c])) w_oob_hit = 1'b1;
    end
  end

  // Read sampling uses the pre-edge array, so same-edge commits are not seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read_data <= '0;
      r_oob       <= 1'b0;
    end else begin
      r_oob <= r_oob | w_oob_hit;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (w_rd_sample[c]) begin
          r_read_data[c] <= in_range(w_rd_address[c]) ? r_mem[idx(w_rd_address[c])] : '0;
        end
      end
    end
  end

  // Later assignments win: channels walk high-to-low, then the load port overrides all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
        if (w_wr_commit[c] && in_range(w_wr_address[c])) r_mem[idx(w_wr_address[c])] <= w_wr_data[c];
      end
      if (load_valid && in_range(load_address)) r_mem[idx(load_address)] <= load_data;
    end
  end

endmodule
`default_nettype wire
